// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared condition-code flag layout and reset value
package cc_pkg;

  localparam int FLAG_W = 5;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  localparam flags_t FLAGS_RST = 5'b01000;

  // Exactly one of N/Z/P is set for any result, which keeps the sign flags one-hot.
  function automatic flags_t derive_flags(input logic msb, input logic is_zero,
                                          input logic c, input logic v);
    flags_t f;
    f         = '0;
    f[FLAG_N] = msb;
    f[FLAG_Z] = is_zero;
    f[FLAG_P] = !msb && !is_zero;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cc_lifo.sv
// rtl/cc_lifo.sv - saved-flag LIFO storage and occupancy pointer
// Push/pop arrive already qualified (never both, never past full/empty).
module cc_lifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 5,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [LW-1:0] r_level;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = AW'(r_level);
  assign w_rd_idx = AW'(r_level - LW'(1));

  assign o_rdata  = r_mem[w_rd_idx];
  assign o_level  = r_level;
  assign o_full   = (r_level == LW'(DEPTH));
  assign o_empty  = (r_level == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level <= '0;
    end else if (i_push) begin
      r_level <= r_level + LW'(1);
    end else if (i_pop) begin
      r_level <= r_level - LW'(1);
    end
  end

  // Storage is left unreset; entries at or above the level are never read.
  always_ff @(posedge clk) begin
    if (reset && i_push) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/cc_stack_unit.sv
// rtl/cc_stack_unit.sv - condition-code register with save/restore LIFO
// Resolves we/push/pop priority, derives flags and keeps the sticky misuse flag.
module cc_stack_unit
  import cc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [WIDTH-1:0]             result,
  input  logic                         c_in,
  input  logic                         v_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  input  logic [2:0]                   cc_mask,
  output logic                         N,
  output logic                         Z,
  output logic                         P,
  output logic                         C,
  output logic                         V,
  output logic                         br_taken,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  flags_t r_flags;
  logic   r_err;
  flags_t w_new_flags;
  flags_t w_pop_flags;
  logic   w_full;
  logic   w_empty;
  logic   w_push_ok;
  logic   w_pop_ok;
  logic   w_err_evt;

  assign w_new_flags = derive_flags(result[WIDTH-1], (result == '0), c_in, v_in);

  // Push and pop together cancel each other; either alone is dropped at the limit.
  assign w_push_ok = push && !pop && !w_full;
  assign w_pop_ok  = pop && !push && !w_empty;
  assign w_err_evt = (push && pop) || (push && w_full) || (pop && w_empty);

  cc_lifo #(
    .DEPTH (DEPTH),
    .DW    (FLAG_W)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_wdata (r_flags),
    .o_rdata (w_pop_flags),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags <= FLAGS_RST;
      r_err   <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_flags <= w_pop_flags;
      end else if (we) begin
        r_flags <= w_new_flags;
      end
      // A fresh error wins over a simultaneous clear.
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign N        = r_flags[FLAG_N];
  assign Z        = r_flags[FLAG_Z];
  assign P        = r_flags[FLAG_P];
  assign C        = r_flags[FLAG_C];
  assign V        = r_flags[FLAG_V];
  assign err      = r_err;
  assign full     = w_full;
  assign empty    = w_empty;
  assign br_taken = |(cc_mask & {N, Z, P});

endmodule

// File: tb/tb_cc_stack_unit.sv
// tb/tb_cc_stack_unit.sv - self-checking bench for cc_stack_unit
module tb_cc_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        we;
  logic [15:0] result;
  logic        c_in;
  logic        v_in;
  logic        push;
  logic        pop;
  logic        clr_err;
  logic [2:0]  cc_mask;
  logic        N, Z, P, C, V;
  logic        br_taken;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  cc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .result   (result),
    .c_in     (c_in),
    .v_in     (v_in),
    .push     (push),
    .pop      (pop),
    .clr_err  (clr_err),
    .cc_mask  (cc_mask),
    .N        (N),
    .Z        (Z),
    .P        (P),
    .C        (C),
    .V        (V),
    .br_taken (br_taken),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        push;
    logic        pop;
    logic        clr;
    logic [2:0]  mask;
    logic [4:0]  flags;
    int          lvl;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [15:0] r, input logic c, input logic v,
                              input logic pu, input logic po, input logic cl, input logic [2:0] m,
                              input logic [4:0] f, input int l, input logic e);
    vec_t t;
    t.we = w; t.res = r; t.c = c; t.v = v; t.push = pu; t.pop = po; t.clr = cl;
    t.mask = m; t.flags = f; t.lvl = l; t.err = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] r, input logic c, input logic v,
                       input logic pu, input logic po, input logic cl, input logic [2:0] m);
    we = w; result = r; c_in = c; v_in = v; push = pu; pop = po; clr_err = cl; cc_mask = m;
  endtask

  task automatic chk_all(input string nm, input logic [4:0] f, input int l, input logic e);
    chk({nm, "_flags"}, {27'd0, N, Z, P, C, V}, {27'd0, f});
    chk({nm, "_level"}, {29'd0, level}, l);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, e});
    chk({nm, "_full"}, {31'd0, full}, {31'd0, (l == DEPTH)});
    chk({nm, "_empty"}, {31'd0, empty}, {31'd0, (l == 0)});
    chk({nm, "_br"}, {31'd0, br_taken}, {31'd0, |(cc_mask & f[4:2])});
  endtask

  // Reference model: flags as a plain vector, the saved stack as a queue.
  logic [4:0] m_flags;
  logic [4:0] m_q[$];
  logic       m_err;

  task automatic model_apply();
    logic [4:0] nf;
    logic       ev;
    if (!reset) begin
      m_flags = 5'b01000;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      ev = 1'b0;
      nf = m_flags;
      if (we) nf = {result[15], (result == 16'd0), (!result[15] && result != 16'd0), c_in, v_in};
      if (push && pop) ev = 1'b1;
      else if (push) begin
        if (m_q.size() == DEPTH) ev = 1'b1;
        else m_q.push_back(m_flags);
      end else if (pop) begin
        if (m_q.size() == 0) ev = 1'b1;
        else nf = m_q.pop_back();
      end
      m_flags = nf;
      if (ev) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 0, 0, 3'b000);
    step();
    step();
    chk_all("reset", 5'b01000, 0, 1'b0);
    reset = 1'b1;

    //           we res      c  v  pu po cl mask     flags     lvl err
    tbl.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 0, 3'b100, 5'b10000, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 3'b100, 5'b01000, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 1, 0, 0, 0, 0, 3'b001, 5'b00110, 0, 0));
    tbl.push_back(mk(0, 16'h8000, 0, 0, 0, 0, 0, 3'b000, 5'b00110, 0, 0));
    tbl.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 0, 3'b100, 5'b10000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b10000, 1, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 3'b010, 5'b01000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3'b100, 5'b10000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b10000, 1, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 0, 0, 0, 0, 3'b000, 5'b01010, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b01010, 2, 0));
    tbl.push_back(mk(1, 16'h0007, 0, 0, 0, 0, 0, 3'b001, 5'b00100, 2, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b00100, 3, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b00100, 4, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 5'b00100, 4, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 5'b00100, 4, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b00100, 3, 0));
    tbl.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 0, 3'b000, 5'b10000, 3, 0));
    tbl.push_back(mk(1, 16'h0001, 0, 1, 1, 0, 0, 3'b001, 5'b00101, 4, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b10000, 3, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b00100, 2, 0));
    tbl.push_back(mk(1, 16'h8000, 0, 0, 1, 1, 0, 3'b000, 5'b10000, 2, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 5'b10000, 2, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b01010, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b10000, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 5'b01000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 1, 3'b000, 5'b01000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 5'b01000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 3'b010, 5'b01000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 3'b101, 5'b01000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 3'b000, 5'b01000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].mask);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].flags, tbl[i].lvl, tbl[i].err);
    end

    // Reset while three entries are saved, with push and we also asserted.
    drive(1, 16'h8000, 1, 1, 1, 0, 0, 3'b000);
    step();
    drive(0, 16'h0000, 0, 0, 1, 0, 0, 3'b000);
    step();
    step();
    chk("pre_reset_level", {29'd0, level}, 32'd3);
    reset = 1'b0;
    drive(1, 16'h8000, 0, 0, 1, 0, 0, 3'b000);
    step();
    chk_all("mid_reset", 5'b01000, 0, 1'b0);
    reset = 1'b1;
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000);
    step();
    chk_all("pop_after_reset", 5'b01000, 0, 1'b1);
    reset = 1'b0;
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 3'b000);
    step();
    chk_all("reset_clears_err", 5'b01000, 0, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      reset = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      we      = $urandom_range(0, 1);
      result  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      c_in    = $urandom_range(0, 1);
      v_in    = $urandom_range(0, 1);
      push    = ($urandom_range(0, 2) == 0);
      pop     = ($urandom_range(0, 2) == 0);
      clr_err = ($urandom_range(0, 7) == 0);
      cc_mask = 3'($urandom_range(0, 7));
      model_apply();
      step();
      chk("rnd_flags", {27'd0, N, Z, P, C, V}, {27'd0, m_flags});
      chk("rnd_level", {29'd0, level}, m_q.size());
      chk("rnd_err", {31'd0, err}, {31'd0, m_err});
      chk("rnd_br", {31'd0, br_taken}, {31'd0, |(cc_mask & m_flags[4:2])});
      chk("rnd_onehot", {31'd0, (N + Z + P) == 2'd1}, 32'd1);
      chk("rnd_full_empty", {30'd0, full, empty}, {30'd0, (m_q.size() == DEPTH), (m_q.size() == 0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
